// File: rtl/tbre_sweep_engine.sv
// Background capability-revocation sweeper.
// Walks 64-bit capability slots and clears tags of revoked capabilities.
module tbre_sweep_engine #(
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [127:0] ctrl_i,
  output logic [63:0]  stat_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [64:0]  mem_wdata_o,
  input  logic         mem_gnt_i,
  input  logic         mem_rvalid_i,
  input  logic [64:0]  mem_rdata_i,
  output logic         rev_req_o,
  output logic [31:0]  rev_addr_o,
  input  logic         rev_ack_i,
  input  logic         rev_revoked_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_REV_REQ = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_WR_WAIT = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] cur_q;
  logic [31:0] end_q;
  logic [64:0] word_q;
  logic        busy_q;
  logic [15:0] cleared_cnt;

  logic        go;
  logic [31:0] start_al;
  logic [31:0] end_in;
  logic [32:0] nxt;
  logic        nxt_last;
  logic        hit;
  logic        unused;

  assign go       = ctrl_i[64];
  assign start_al = {ctrl_i[31:3], 3'b000};
  assign end_in   = ctrl_i[63:32];
  assign nxt      = {1'b0, cur_q} + 33'd8;
  assign nxt_last = nxt[32] || (nxt >= {1'b0, end_q});
  assign hit      = rev_ack_i && rev_revoked_i;

  assign unused = ^{ctrl_i[127:65], word_q[64],
                    (MAX_OUTSTANDING == 1)};

  // Sweep sequencing: read slot, look up tagged ones, clear revoked ones
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (start_al >= end_in) state_d = S_DONE;
          else                    state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (mem_gnt_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_rdata_i[64]) state_d = S_REV_REQ;
          else                 state_d = S_NEXT;
        end
      end
      S_REV_REQ: begin
        if (rev_ack_i) begin
          if (rev_revoked_i) state_d = S_WR_REQ;
          else               state_d = S_NEXT;
        end
      end
      S_WR_REQ:  if (mem_gnt_i) state_d = S_WR_WAIT;
      S_WR_WAIT: if (mem_rvalid_i) state_d = S_NEXT;
      S_NEXT: begin
        if (nxt_last) state_d = S_DONE;
        else          state_d = S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, busy flag, range pointers, latched slot and revoke counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      cur_q       <= '0;
      end_q       <= '0;
      word_q      <= '0;
      cleared_cnt <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (state_q == S_IDLE && go) begin
        cur_q       <= start_al;
        end_q       <= end_in;
        cleared_cnt <= '0;
      end
      if (state_q == S_NEXT && !nxt_last) begin
        cur_q <= nxt[31:0];
      end
      if (state_q == S_RD_WAIT && mem_rvalid_i) begin
        word_q <= mem_rdata_i;
      end
      if (state_q == S_REV_REQ && hit &&
          cleared_cnt != 16'hFFFF) begin
        cleared_cnt <= cleared_cnt + 16'd1;
      end
    end
  end

  // Port drive decoded from the state register; idle values are zero
  always_comb begin
    mem_req_o   = (state_q == S_RD_REQ) ||
                  (state_q == S_WR_REQ);
    mem_we_o    = (state_q == S_WR_REQ);
    mem_addr_o  = mem_req_o ? cur_q : 32'd0;
    mem_wdata_o = '0;
    if (state_q == S_WR_REQ) begin
      mem_wdata_o = {1'b0, word_q[63:0]};
    end
    rev_req_o  = (state_q == S_REV_REQ);
    rev_addr_o = rev_req_o ? word_q[31:0] : 32'd0;
    stat_o     = {63'd0, busy_q};
  end

endmodule
